mem_fifo_ctrl: RTL and testbench

//  FIFO controller sitting directly upstream of the 1024x8 single-port mem_array; drives its

---
 rtl/mem_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_fifo_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a single-port, 1-cycle-latency memory, with a one-word output register.
// Define MEM_FIFO_ALMOST_EN to add the registered almost_full output.
module mem_fifo_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int AFULL_THRESH = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W:0]   count
`ifdef MEM_FIFO_ALMOST_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   mem_cnt_reg, mem_cnt_next;
    logic              rd_inflight_reg, rd_inflight_next;
    logic              rd_valid_reg, rd_valid_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic              prio_reg, prio_next;
    logic              want_rd, want_wr, grant_rd, grant_wr, pop;
    logic [ADDR_W:0]   count_next;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    always_comb begin
        want_rd  = (mem_cnt_reg != '0) && !rd_inflight_reg && (!rd_valid_reg || rd_ready);
        want_wr  = wr_valid && (mem_cnt_reg < DEPTH_CNT);
        grant_rd = want_rd && (!want_wr || !prio_reg);
        grant_wr = want_wr && !grant_rd;
        pop      = rd_valid_reg && rd_ready;
    end

    // wr_ready depends combinationally on rd_ready through the read grant.
    assign wr_ready     = (mem_cnt_reg < DEPTH_CNT) && !grant_rd;
    assign mem_write_en = grant_wr && rst_n;
    assign mem_address  = grant_rd ? rd_ptr_reg : wr_ptr_reg;
    assign mem_data_in  = wr_data;
    assign rd_valid     = rd_valid_reg;
    assign rd_data      = rd_data_reg;
    assign count        = mem_cnt_reg + (ADDR_W+1)'(rd_inflight_reg) + (ADDR_W+1)'(rd_valid_reg);

    always_comb begin
        wr_ptr_next      = grant_wr ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next      = grant_rd ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        mem_cnt_next     = mem_cnt_reg;
        if (grant_wr)
            mem_cnt_next = mem_cnt_reg + (ADDR_W+1)'(1);
        else if (grant_rd)
            mem_cnt_next = mem_cnt_reg - (ADDR_W+1)'(1);
        rd_inflight_next = grant_rd;
        rd_valid_next    = rd_valid_reg;
        rd_data_next     = rd_data_reg;
        // A landing word refills the output register even when it is popped the same cycle.
        if (rd_inflight_reg) begin
            rd_valid_next = 1'b1;
            rd_data_next  = mem_data_out;
        end else if (pop) begin
            rd_valid_next = 1'b0;
        end
        prio_next  = (want_rd && want_wr) ? !prio_reg : prio_reg;
        count_next = mem_cnt_next + (ADDR_W+1)'(rd_inflight_next) + (ADDR_W+1)'(rd_valid_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            mem_cnt_reg     <= '0;
            rd_inflight_reg <= 1'b0;
            rd_valid_reg    <= 1'b0;
            rd_data_reg     <= '0;
            prio_reg        <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            mem_cnt_reg     <= mem_cnt_next;
            rd_inflight_reg <= rd_inflight_next;
            rd_valid_reg    <= rd_valid_next;
            rd_data_reg     <= rd_data_next;
            prio_reg        <= prio_next;
        end
    end

`ifdef MEM_FIFO_ALMOST_EN
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_THRESH);
    logic almost_full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            almost_full_reg <= 1'b0;
        else
            almost_full_reg <= (count_next >= AFULL_CNT);
    end

    assign almost_full = almost_full_reg;
`else
    logic unused_count_next;
    assign unused_count_next = ^count_next;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl (DEPTH=16) with a 1-clk-latency memory model and a data scoreboard.
module tb_mem_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int THRESH = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_data_out;
    logic [ADDR_W:0]   count;
`ifdef MEM_FIFO_ALMOST_EN
    logic              almost_full;
`endif

    mem_fifo_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AFULL_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
        .count(count)
`ifdef MEM_FIFO_ALMOST_EN
        , .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_model [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_write_en) mem_model[mem_address] <= mem_data_in;
        mem_data_out <= mem_model[mem_address];
    end

    int                errors = 0;
    int                checks = 0;
    logic [DATA_W-1:0] q[$];
    logic [ADDR_W-1:0] exp_wa = '0;
    logic              last_acc_wr = 1'b0;
    int                n_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample just after the falling edge, update the scoreboard, then advance one clock.
    task automatic cyc();
        logic [DATA_W-1:0] exp_d;
        #1;
        check("count_vs_scoreboard", 32'(count), 32'(q.size()));
        check("write_iff_accepted", 32'(mem_write_en), 32'(wr_valid && wr_ready));
        if (mem_write_en) begin
            check("write_address", 32'(mem_address), 32'(exp_wa));
            exp_wa = (exp_wa == ADDR_W'(DEPTH - 1)) ? '0 : exp_wa + 1'b1;
        end
`ifdef MEM_FIFO_ALMOST_EN
        check("almost_full", 32'(almost_full), 32'(q.size() >= THRESH));
`endif
        last_acc_wr = wr_valid && wr_ready;
        if (rd_valid && rd_ready) begin
            check("pop_with_data_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                exp_d = q.pop_front();
                check("pop_data", 32'(rd_data), 32'(exp_d));
                $display("pop  %h (expected %h)", rd_data, exp_d);
            end
        end
        if (last_acc_wr) begin
            q.push_back(wr_data);
            $display("push %h", wr_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (last_acc_wr) break;
        end
        check("push_accepted", 32'(last_acc_wr), 32'd1);
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 300 && q.size() > 0; i++) cyc();
        check("drain_complete", 32'(q.size()), 32'd0);
        rd_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a push request pending: no write may reach memory.
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        repeat (3) @(negedge clk);
        #1;
        check("reset_count", 32'(count), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_write_en", 32'(mem_write_en), 32'd0);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk);

        // Three pushes with the output held.
        push(8'hAA);
        push(8'h55);
        push(8'hFF);
        repeat (4) cyc();
        #1;
        check("t1_rd_data", 32'(rd_data), 32'hAA);
        check("t1_rd_valid", 32'(rd_valid), 32'd1);
        check("t1_count", 32'(count), 32'd3);

        // Pop all three in order.
        drain();
        #1;
        check("t2_rd_valid", 32'(rd_valid), 32'd0);
        check("t2_count", 32'(count), 32'd0);

        // Fill to capacity: 16 in memory plus the output register.
        wr_valid = 1'b1;
        n_acc    = 0;
        for (int i = 0; i < 60 && n_acc < 20; i++) begin
            wr_data = 8'(8'h40 + n_acc);
            cyc();
            if (last_acc_wr) n_acc++;
        end
        #1;
        check("t3_accepted", 32'(n_acc), 32'd17);
        check("t3_wr_ready_full", 32'(wr_ready), 32'd0);
        check("t3_count", 32'(count), 32'd17);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wr_ready) break;
            cyc();
        end
        check("t3_wr_ready_back", 32'(wr_ready), 32'd1);
        drain();

        // Streaming with both sides active; addresses wrap past 15.
        rd_ready = 1'b1;
        for (int k = 0; k < 50; k++) push(8'(k * 7 + 3));
        drain();

        // Asynchronous reset while a read is in flight.
        for (int k = 0; k < 6; k++) push(8'(8'hC0 + k));
        repeat (2) cyc();
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        #1;
        check("t5_count_before_reset", 32'(count), 32'd5);
        wr_valid = 1'b1;
        wr_data  = 8'h33;
        rst_n    = 1'b0;
        #1;
        check("t5_count_in_reset", 32'(count), 32'd0);
        check("t5_rd_valid_in_reset", 32'(rd_valid), 32'd0);
        check("t5_write_en_in_reset", 32'(mem_write_en), 32'd0);
        @(negedge clk);
        #1;
        check("t5_write_en_held", 32'(mem_write_en), 32'd0);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        q.delete();
        exp_wa   = '0;
        @(negedge clk);
        push(8'hAA);
        drain();

`ifdef MEM_FIFO_ALMOST_EN
        for (int k = 0; k < THRESH; k++) push(8'(8'h80 + k));
        repeat (3) cyc();
        #1;
        check("t6_almost_full_set", 32'(almost_full), 32'd1);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        #1;
        check("t6_count_11", 32'(count), 32'd11);
        check("t6_almost_full_clear", 32'(almost_full), 32'd0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
